serial_frame_buffer: RTL and testbench

//  Receives a bit-serial sample stream from the Raspberry Pi and assembles it into multi-channel

---
 rtl/serial_frame_pkg.sv | 28 ++
 rtl/rpi_serial_rx.sv | 108 ++++++++++
 rtl/serial_frame_buffer.sv | 175 +++++++++++++++++
 tb/tb_serial_frame_buffer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_pkg
// Purpose  : Shared state encodings, synchroniser depth and pointer-width
//            helper for the serial frame buffer.
// Revision : 1.0 - initial release
// ============================================================================
package serial_frame_pkg;

  typedef enum logic [0:0] {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

  typedef enum logic [0:0] {
    PRIME = 1'b0,
    RUN   = 1'b1
  } rd_state_t;

  localparam int SYNC_STAGES = 2;

  // One extra pointer bit distinguishes a full FIFO from an empty one.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rpi_serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : rpi_serial_rx
// Purpose  : Synchronises the Pi serial link into clk, detects shift-clock
//            rising edges and deserialises LSB-first words into frames.
// Revision : 1.0 - initial release
// ============================================================================
module rpi_serial_rx
  import serial_frame_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rpi_clk,
  input  logic                        serial,
  input  logic                        rpi_frame,
  output logic [CHANNELS*WIDTH-1:0]   frame,
  output logic                        frame_push
);

  localparam int FRAME_BITS = CHANNELS * WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] ser_sync_q, ser_sync_d;
  logic [SYNC_STAGES-1:0] frm_sync_q, frm_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  rx_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]  sr_q, sr_d;
  logic                   push_q, push_d;
  logic                   bit_stb;
  logic                   bit_val;
  logic                   bit_sof;

  // Synchroniser chains and the rising-edge detector on the shift clock.
  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], rpi_clk};
    ser_sync_d = {ser_sync_q[SYNC_STAGES-2:0], serial};
    frm_sync_d = {frm_sync_q[SYNC_STAGES-2:0], rpi_frame};
    clk_prev_d = clk_sync_q[SYNC_STAGES-1];
    bit_stb    = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
    bit_val    = ser_sync_q[SYNC_STAGES-1];
    bit_sof    = frm_sync_q[SYNC_STAGES-1];
  end

  // Rx FSM: right-shifting register leaves the first bit in the LSB once full.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    push_d  = 1'b0;
    if (bit_stb) begin
      case (state_q)
        HUNT: begin
          if (bit_sof) begin
            state_d = SHIFT;
            sr_d    = {bit_val, sr_q[FRAME_BITS-1:1]};
            cnt_d   = CNT_W'(1);
          end
        end
        SHIFT: begin
          sr_d  = {bit_val, sr_q[FRAME_BITS-1:1]};
          cnt_d = bit_sof ? CNT_W'(1) : cnt_q + CNT_W'(1);
        end
        default: state_d = HUNT;
      endcase
      if ((state_d == SHIFT) && (cnt_d == CNT_W'(FRAME_BITS))) begin
        push_d = 1'b1;
        cnt_d  = '0;
      end
    end
  end

  // Rx FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  // Synchroniser, counter, shift register and push strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= '0;
      ser_sync_q <= '0;
      frm_sync_q <= '0;
      clk_prev_q <= 1'b0;
      cnt_q      <= '0;
      sr_q       <= '0;
      push_q     <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      ser_sync_q <= ser_sync_d;
      frm_sync_q <= frm_sync_d;
      clk_prev_q <= clk_prev_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      push_q     <= push_d;
    end
  end

  assign frame      = sr_q;
  assign frame_push = push_q;

endmodule
`default_nettype wire

// File: rtl/serial_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_buffer
// Purpose  : Circular FIFO of multi-channel frames received from the Pi,
//            read one frame per ready strobe, with hysteretic refill request.
//            Optional macro SFB_ERR_COUNT_EN adds saturating error counters.
// Revision : 1.0 - initial release
// ============================================================================
module serial_frame_buffer
  import serial_frame_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CHANNELS   = 2,
  parameter int DEPTH      = 64,
  parameter int LOW_WATER  = 16,
  parameter int HIGH_WATER = 48
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rpi_clk,
  input  logic                      serial,
  input  logic                      rpi_frame,
  input  logic                      ready,
  input  logic                      clr_err,
  output logic [CHANNELS*WIDTH-1:0] data,
  output logic                      data_valid,
  output logic                      rpi_interrupt,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overrun,
`ifdef SFB_ERR_COUNT_EN
  output logic [7:0]                overrun_cnt,
  output logic [7:0]                underrun_cnt,
`endif
  output logic                      underrun
);

  localparam int FRAME_BITS = CHANNELS * WIDTH;
  localparam int PTR_W      = ptr_width(DEPTH);
  localparam int ADDR_W     = PTR_W - 1;

  logic [FRAME_BITS-1:0] rx_frame;
  logic                  rx_push;
  logic [FRAME_BITS-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      level_q, level_d;
  rd_state_t             rd_state_q, rd_state_d;
  logic [FRAME_BITS-1:0] data_q, data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  irq_q, irq_d;
  logic                  overrun_q, overrun_d;
  logic                  underrun_q, underrun_d;
  logic                  fifo_empty, fifo_full;
  logic                  pop_req, pop_ok, push_ok;
  logic                  ovr_evt, udr_evt;

  rpi_serial_rx #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rpi_clk    (rpi_clk),
    .serial     (serial),
    .rpi_frame  (rpi_frame),
    .frame      (rx_frame),
    .frame_push (rx_push)
  );

  // Push/pop arbitration: a pop frees a slot for a same-cycle push when full;
  // a pop on an empty FIFO is refused even if a push lands alongside it.
  always_comb begin
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == PTR_W'(DEPTH));
    pop_req    = (rd_state_q == RUN) && ready;
    pop_ok     = pop_req && !fifo_empty;
    push_ok    = rx_push && (!fifo_full || pop_ok);
    ovr_evt    = rx_push && !push_ok;
    udr_evt    = pop_req && fifo_empty;
  end

  // Rd FSM next state: wait for the prime level, fall back on underrun.
  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      PRIME:   if (level_q >= PTR_W'(HIGH_WATER)) rd_state_d = RUN;
      RUN:     if (udr_evt) rd_state_d = PRIME;
      default: rd_state_d = PRIME;
    endcase
  end

  // Pointers, level, output frame, refill request and sticky flags.
  always_comb begin
    wr_ptr_d     = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d     = rd_ptr_q + PTR_W'(pop_ok);
    level_d      = wr_ptr_d - rd_ptr_d;
    data_d       = pop_ok ? mem_q[rd_ptr_q[ADDR_W-1:0]] : data_q;
    data_valid_d = pop_ok;
    irq_d        = irq_q;
    if (level_q < PTR_W'(LOW_WATER))        irq_d = 1'b1;
    else if (level_q >= PTR_W'(HIGH_WATER)) irq_d = 1'b0;
    overrun_d    = (overrun_q && !clr_err) || ovr_evt;
    underrun_d   = (underrun_q && !clr_err) || udr_evt;
  end

  // Frame storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[ADDR_W-1:0]] <= rx_frame;
  end

  // Rd FSM state register.
  always_ff @(posedge clk) begin
    if (rst) rd_state_q <= PRIME;
    else     rd_state_q <= rd_state_d;
  end

  // Datapath and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      irq_q        <= 1'b0;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      irq_q        <= irq_d;
      overrun_q    <= overrun_d;
      underrun_q   <= underrun_d;
    end
  end

`ifdef SFB_ERR_COUNT_EN
  logic [7:0] ovr_cnt_q, ovr_cnt_d;
  logic [7:0] udr_cnt_q, udr_cnt_d;

  // Saturating event counters; an event in the clearing cycle counts as one.
  always_comb begin
    ovr_cnt_d = clr_err ? 8'd0 : ovr_cnt_q;
    udr_cnt_d = clr_err ? 8'd0 : udr_cnt_q;
    if (ovr_evt && (ovr_cnt_d != 8'hFF)) ovr_cnt_d = ovr_cnt_d + 8'd1;
    if (udr_evt && (udr_cnt_d != 8'hFF)) udr_cnt_d = udr_cnt_d + 8'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_cnt_q <= 8'd0;
      udr_cnt_q <= 8'd0;
    end else begin
      ovr_cnt_q <= ovr_cnt_d;
      udr_cnt_q <= udr_cnt_d;
    end
  end

  assign overrun_cnt  = ovr_cnt_q;
  assign underrun_cnt = udr_cnt_q;
`endif

  assign data          = data_q;
  assign data_valid    = data_valid_q;
  assign rpi_interrupt = irq_q;
  assign level         = level_q;
  assign overrun       = overrun_q;
  assign underrun      = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_frame_buffer
// Purpose  : Directed-plus-random bench for serial_frame_buffer against a
//            queue-based model of the frame FIFO, read state and flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_frame_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rpi_clk = 1'b0;
  logic        serial = 1'b0;
  logic        rpi_frame = 1'b0;
  logic        ready = 1'b0;
  logic        clr_err = 1'b0;
  logic [31:0] data;
  logic        data_valid;
  logic        rpi_interrupt;
  logic [6:0]  level;
  logic        overrun;
  logic        underrun;
`ifdef SFB_ERR_COUNT_EN
  logic [7:0]  overrun_cnt;
  logic [7:0]  underrun_cnt;
`endif

  int          total = 0;
  int          bad = 0;

  // Reference model state
  logic [31:0] q[$];
  bit          run_m = 1'b0;
  bit          int_m = 1'b0;
  bit          ovr_m = 1'b0;
  bit          udr_m = 1'b0;
  logic [31:0] last_d = 32'h0;

  serial_frame_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .rpi_clk       (rpi_clk),
    .serial        (serial),
    .rpi_frame     (rpi_frame),
    .ready         (ready),
    .clr_err       (clr_err),
    .data          (data),
    .data_valid    (data_valid),
    .rpi_interrupt (rpi_interrupt),
    .level         (level),
    .overrun       (overrun),
`ifdef SFB_ERR_COUNT_EN
    .overrun_cnt   (overrun_cnt),
    .underrun_cnt  (underrun_cnt),
`endif
    .underrun      (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hysteresis and prime rules evaluated on the model level.
  task automatic model_update();
    if (q.size() < 16)       int_m = 1'b1;
    else if (q.size() >= 48) int_m = 1'b0;
    if (q.size() >= 48)      run_m = 1'b1;
  endtask

  task automatic model_push(input logic [31:0] f);
    if (q.size() < 64) q.push_back(f);
    else               ovr_m = 1'b1;
    model_update();
  endtask

  // Pop decision made on the level before any same-cycle push.
  task automatic model_pop(output bit v);
    v = 1'b0;
    if (run_m) begin
      if (q.size() > 0) begin
        last_d = q.pop_front();
        v = 1'b1;
      end else begin
        udr_m = 1'b1;
        run_m = 1'b0;
      end
    end
  endtask

  task automatic send_bit(input logic b, input logic f);
    rpi_clk = 1'b0; serial = b; rpi_frame = f;
    #40;
    rpi_clk = 1'b1;
    #40;
  endtask

  task automatic send_frame(input logic [31:0] f);
    for (int i = 0; i < 32; i++) send_bit(f[i], i == 0);
    model_push(f);
  endtask

  task automatic check_state(input string tag);
    repeat (3) @(negedge clk);
    chk({tag, ".level"},    64'(level),         64'(q.size()));
    chk({tag, ".irq"},      64'(rpi_interrupt), 64'(int_m));
    chk({tag, ".overrun"},  64'(overrun),       64'(ovr_m));
    chk({tag, ".underrun"}, 64'(underrun),      64'(udr_m));
  endtask

  task automatic do_ready(input string tag);
    bit v;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    model_pop(v);
    model_update();
    chk({tag, ".valid"}, 64'(data_valid), 64'(v));
    chk({tag, ".data"},  64'(data),       64'(last_d));
    check_state(tag);
  endtask

  // Last bit timed so ready is sampled on the same edge the frame is pushed.
  task automatic push_with_ready(input string tag, input logic [31:0] f);
    bit v;
    for (int i = 0; i < 31; i++) send_bit(f[i], i == 0);
    rpi_clk = 1'b0; serial = f[31]; rpi_frame = 1'b0;
    #40;
    rpi_clk = 1'b1;
    repeat (3) @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    model_pop(v);
    model_push(f);
    chk({tag, ".valid"}, 64'(data_valid), 64'(v));
    chk({tag, ".data"},  64'(data),       64'(last_d));
    check_state(tag);
  endtask

  task automatic pulse_clr(input string tag);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    ovr_m = 1'b0;
    udr_m = 1'b0;
    check_state(tag);
  endtask

  initial begin
    logic [31:0] f;
    logic [15:0] i16;

    // 1: reset state and idle behaviour
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.data",  64'(data),          64'h0);
    chk("rst.valid", 64'(data_valid),    64'h0);
    chk("rst.irq",   64'(rpi_interrupt), 64'h0);
    chk("rst.level", 64'(level),         64'h0);
    chk("rst.ovr",   64'(overrun),       64'h0);
    chk("rst.udr",   64'(underrun),      64'h0);
    rst = 1'b0;
    chk("rst.irq_fall_cycle", 64'(rpi_interrupt), 64'h0);
    @(negedge clk);
    chk("rst.irq_next_cycle", 64'(rpi_interrupt), 64'h1);
    int_m = 1'b1;
    do_ready("idle_ready0");
    do_ready("idle_ready1");
    for (int i = 0; i < 40; i++) send_bit(1'($urandom), 1'b0);
    check_state("hunt_no_sync");

    // 2: prime with 48 ramp frames
    for (int i = 0; i < 48; i++) begin
      i16 = 16'(i);
      send_frame({~i16, i16});
      check_state($sformatf("fill48_%0d", i));
    end
    do_ready("first_read");

    // 3: drain past low water, then underrun and PRIME behaviour
    while (q.size() > 0) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_ready($sformatf("drain_lvl%0d", q.size()));
    end
    do_ready("underrun_ready");
    pulse_clr("clr_after_udr");
    do_ready("prime_ignores_ready");

    // 5: sync mid-word after 7 bits discards the partial frame
    send_bit(1'($urandom), 1'b1);
    for (int i = 1; i < 7; i++) send_bit(1'($urandom), 1'b0);
    f = {16'($urandom), 16'h0000};
    send_frame(f);
    check_state("resync");

    // 4: fill to 64 then overflow
    for (int i = 1; i < 64; i++) begin
      f = {16'($urandom), 16'(i)};
      send_frame(f);
    end
    check_state("full64");
    send_frame(32'($urandom));
    check_state("overflow65");
    pulse_clr("clr_after_ovr");

    // 6a: push and pop together at full
    push_with_ready("pushpop_full", 32'($urandom));

    // 4 (cont.): read back in order until empty
    while (q.size() > 0) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_ready($sformatf("readback_lvl%0d", q.size()));
    end

    // 6b: push and pop together at empty
    push_with_ready("pushpop_empty", 32'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
